// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state encodings and width helper for the FIFO blocks.
package fifo_pkg;
    localparam logic IDLE = 1'b0;
    localparam logic BURST = 1'b1;

    typedef enum logic {ST_IDLE = IDLE, ST_BURST = BURST} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo_wrt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request after last_grant wins.
module rr_pick import fifo_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int GW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic               found,
    output logic [GW-1:0]      index
);
    int idx;

    // Scan farthest-first so the nearest requester after last_grant overwrites.
    always_comb begin
        found = 1'b0;
        index = '0;
        idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req[idx]) begin
                found = 1'b1;
                index = GW'(idx);
            end
        end
    end
endmodule

// File: rtl/fifo_wrt_arbiter.sv
// fifo_wrt_arbiter: round-robin burst arbiter sharing the FIFO write port.
module fifo_wrt_arbiter import fifo_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           wrt_clk,
    input  logic                           wrt_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wrt_full,
    output logic                           wrt_inc,
    output logic [DATA_SIZE-1:0]           wrt_data,
    output logic [clog2(NUM_REQ)-1:0]      grant_id,
    output logic                           busy
);
    localparam int GW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_BURST + 1);

    state_t         state, state_nxt;
    logic [GW-1:0]  last_grant, pick;
    logic [CW-1:0]  burst_cnt;
    logic           found, xfer, done;

    rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
        .req(req_valid),
        .last_grant(last_grant),
        .found(found),
        .index(pick)
    );

    // Release also covers the granted requester dropping valid, even while full.
    always_comb begin
        busy = state == ST_BURST;
        xfer = busy && req_valid[grant_id] && !wrt_full;
        req_ready = busy && !wrt_full ? NUM_REQ'(1) << grant_id : '0;
        wrt_inc = xfer;
        wrt_data = req_data[grant_id*DATA_SIZE +: DATA_SIZE];
        done = !req_valid[grant_id] || (xfer && (req_last[grant_id] || burst_cnt == CW'(MAX_BURST - 1)));
        state_nxt = state == ST_IDLE ? (found ? ST_BURST : ST_IDLE) : (done ? ST_IDLE : ST_BURST);
    end

    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            state <= ST_IDLE;
            grant_id <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && found) begin
                grant_id <= pick;
                last_grant <= pick;
                burst_cnt <= '0;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/fifo_wrt_arbiter.md
# fifo_wrt_arbiter

Write-domain arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters. It grants one requester at a time in round-robin order and holds the grant for a bounded burst. It drives wrt_inc and wrt_data into the FIFO write-pointer generator and memory, and throttles every requester on wrt_full. All logic is in the wrt_clk domain; it never observes read-side signals.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_SIZE, 8: FIFO word width
- MAX_BURST, 4: maximum words per grant, 1..16
- wrt_clk  in  1  write clock
- wrt_rst  in  1  reset wrt_rst, asynchronous, active-high; clock wrt_clk
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_SIZE  requester i data at bits [i*DATA_SIZE +: DATA_SIZE]
- req_last  in  NUM_REQ  marks final word of requester's packet
- req_ready  out  NUM_REQ  one-hot or zero; word accepted when valid & ready
- wrt_full  in  1  registered full flag from write-pointer generator
- wrt_inc  out  1  FIFO write strobe
- wrt_data  out  DATA_SIZE  FIFO write data
- grant_id  out  clog2(NUM_REQ)  currently/last granted requester
- busy  out  1  high while in BURST state

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any req_valid, pick first valid index scanning from last_grant+1 (mod NUM_REQ) upward; register grant_id, last_grant <= pick, burst_cnt <= 0, go to BURST. No transfer in IDLE.
- BURST: req_ready[grant_id] = !wrt_full; all other ready bits 0. Transfer = req_valid[grant_id] & req_ready[grant_id].
- wrt_inc = transfer; wrt_data = req_data slice of grant_id (combinational mux; don't-care when wrt_inc=0).
- On transfer: burst_cnt++.
- Exit BURST -> IDLE when any of: transfer with req_last[grant_id]; transfer with burst_cnt == MAX_BURST-1; req_valid[grant_id] low (release, regardless of wrt_full).
- wrt_full high in BURST: ready low, no wrt_inc, burst_cnt and grant held; no timeout.
- Non-granted requesters may change valid/data freely; granted requester must hold data stable while valid & !ready.
- burst_cnt width clog2(MAX_BURST+1); never exceeds MAX_BURST-1.
- wrt_inc is never asserted while wrt_full is high (arbiter guarantees; generator gating is redundant).

## Timing
- Reset values: state IDLE, grant_id 0, last_grant NUM_REQ-1 (requester 0 has first priority), burst_cnt 0, req_ready 0, wrt_inc 0, busy 0.
- Reset mid-burst: immediately to reset values; partial packet is abandoned.
- Latency: req_valid in IDLE at cycle N -> grant registered edge N+1 -> ready/wrt_inc earliest in cycle N+1.
- One IDLE bubble cycle between consecutive bursts.
- Peak throughput: MAX_BURST words per MAX_BURST+1 cycles.
- wrt_full is sampled combinationally into req_ready/wrt_inc in the same cycle.

## Structure
- Shared package fifo_pkg: FSM state localparams (IDLE=0, BURST=1) and a clog2 constant function for use by other FIFO blocks.
- Sub-module rr_pick: combinational round-robin picker (inputs req vector, last_grant; outputs found, index).
- Top holds FSM, burst counter, last_grant register, data mux.

## Test plan
- Reset, requester 2 valid with 3 words, last on word 3, MAX_BURST=4 -> grant_id=2 one cycle later, 3 wrt_inc pulses in consecutive cycles, return to IDLE.
- All 4 requesters continuously valid, no last -> grants 0,1,2,3,0 in order, exactly 4 words each, one bubble between bursts.
- wrt_full asserted for 5 cycles mid-burst after word 2 -> no wrt_inc, ready low, grant held; words 3–4 resume after full drops.
- Granted requester drops valid after 1 word -> release to IDLE, next valid requester granted next cycle, burst_cnt restarts at 0.
- wrt_rst asserted asynchronously mid-burst -> outputs zero immediately; after release, requester 0 has priority over 3 when both valid.
- MAX_BURST=1, requesters 1 and 3 valid -> alternating single-word grants 1,3,1,3; wrt_data matches the granted slice each pulse.
